// File: rtl/velocity_cell_dbuf.sv
// Double-buffered velocity record store: reads hit the active bank, writes the shadow bank.
// Define VEL_OUTREG_EN to add an output register stage (read latency 2 instead of 1).
module velocity_cell_dbuf #(
    parameter int DATA_WIDTH   = 96,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  swap_req,
    output logic                  swap_done,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] active_cnt,
    output logic                  wr_err
);

    localparam logic [ADDR_WIDTH:0] ADDR_LIM = (ADDR_WIDTH+1)'(PARTICLE_NUM);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        SWAP
    } state_t;

    state_t state;

    logic                  bank_sel;
    logic [ADDR_WIDTH-1:0] cnt0;
    logic [ADDR_WIDTH-1:0] cnt1;

    logic [DATA_WIDTH-1:0] mem0 [PARTICLE_NUM];
    logic [DATA_WIDTH-1:0] mem1 [PARTICLE_NUM];

    logic                  rd_ok;
    logic                  wr_ok;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  drain_clear;
    logic [DATA_WIDTH-1:0] rd_word;

    assign rd_ok   = {1'b0, rd_addr} < ADDR_LIM;
    assign wr_ok   = {1'b0, wr_addr} < ADDR_LIM;
    assign rd_acc  = rd_en && rd_ok && (state == RUN);
    assign wr_acc  = wr_en && wr_ok;
    assign rd_word = bank_sel ? mem1[rd_addr] : mem0[rd_addr];

    // Counts live with their bank, so toggling bank_sel exchanges them.
    assign active_cnt = bank_sel ? cnt1 : cnt0;

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            if (bank_sel) begin
                mem0[wr_addr] <= wr_data;
            end else begin
                mem1[wr_addr] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (wr_acc && (wr_addr == '0)) begin
            if (bank_sel) begin
                cnt0 <= wr_data[ADDR_WIDTH-1:0];
            end else begin
                cnt1 <= wr_data[ADDR_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_en && !wr_ok;
        end
    end

`ifdef VEL_OUTREG_EN
    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;

    assign drain_clear = !s1_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            s1_valid <= rd_acc;
            s1_data  <= rd_acc ? rd_word : '0;
            rd_valid <= s1_valid;
            rd_data  <= s1_valid ? s1_data : '0;
        end
    end
`else
    // The only stage is the output register, so nothing is ever left behind it.
    assign drain_clear = 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_acc;
            rd_data  <= rd_acc ? rd_word : '0;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            bank_sel  <= 1'b0;
            busy      <= 1'b0;
            swap_done <= 1'b0;
        end else begin
            swap_done <= 1'b0;
            unique case (state)
                RUN: begin
                    if (swap_req) begin
                        state <= DRAIN;
                        busy  <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_clear) begin
                        state <= SWAP;
                    end
                end
                SWAP: begin
                    bank_sel  <= ~bank_sel;
                    swap_done <= 1'b1;
                    busy      <= 1'b0;
                    state     <= RUN;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_velocity_cell_dbuf.sv
// Directed bench for velocity_cell_dbuf with a read-return scoreboard.
// Define VEL_OUTREG_EN to match a DUT built with the output register stage.
module tb_velocity_cell_dbuf;

    localparam int DW = 96;
    localparam int AW = 8;
    localparam int PN = 220;
`ifdef VEL_OUTREG_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          swap_req = 1'b0;
    logic          swap_done;
    logic          busy;
    logic [AW-1:0] active_cnt;
    logic          wr_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic          mbank = 1'b0;
    logic [DW-1:0] mdl [2][256];

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t q[$];

    velocity_cell_dbuf dut (
        .clk(clk),
        .rst(rst),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .swap_req(swap_req),
        .swap_done(swap_done),
        .busy(busy),
        .active_cnt(active_cnt),
        .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rec(input int v);
        logic [31:0] w;
        w = v;
        return {w, w, w};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drive_rd(input int a, input bit expect_v);
        exp_t e;
        rd_en   = 1'b1;
        rd_addr = AW'(a);
        if (expect_v) begin
            e.data = mdl[mbank][a];
            e.due  = cyc + L;
            q.push_back(e);
        end
    endtask

    task automatic drive_wr(input int a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        if (a < PN) mdl[~mbank][a] = d;
    endtask

    task automatic idle_io();
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic wait_q(input string tag);
        for (int i = 0; i < 10 && q.size() > 0; i++) tick();
        tick();
        chk(tag, q.size(), 0);
    endtask

    // Scoreboard: every valid return must match the oldest expected read on time.
    always @(negedge clk) begin
        exp_t e;
        if (rd_valid) begin
            if (q.size() == 0) begin
                chk("rd_spurious", 1, 0);
            end else begin
                e = q.pop_front();
                chk("rd_data", rd_data, e.data);
                chk("rd_lat", cyc, e.due);
            end
        end else begin
            chk("rd_zero", rd_data, 0);
            if (q.size() > 0 && q[0].due < cyc) begin
                chk("rd_missing", cyc, q[0].due);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", swap_done, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_cnt", active_cnt, 0);
        chk("rst_wrerr", wr_err, 0);
        rst = 1'b0;
        tick();

        // Fill shadow bank and swap with no reads in flight
        drive_wr(0, rec(5));
        tick();
        for (int i = 1; i <= 5; i++) begin
            drive_wr(i, rec(i));
            tick();
        end
        idle_io();
        chk("wr_ok_noerr", wr_err, 0);
        chk("pre_swap_cnt", active_cnt, 0);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        chk("swap1_busy", busy, 1);
        chk("swap1_nodone", swap_done, 0);
        tick();
        chk("swap1_busy2", busy, 1);
        tick();
        mbank = 1'b1;
        chk("swap1_done", swap_done, 1);
        chk("swap1_clr", busy, 0);
        chk("swap1_cnt", active_cnt, 5);
        tick();
        chk("swap1_pulse", swap_done, 0);

        drive_rd(3, 1);
        tick();
        idle_io();
        wait_q("q_rd3");

        // Back-to-back reads with same-address shadow writes
        for (int i = 1; i <= 4; i++) begin
            drive_rd(i, 1);
            drive_wr(i, rec(100 + i));
            tick();
        end
        idle_io();
        wait_q("q_b2b");

        // Out-of-range write and read
        drive_wr(PN, rec(77));
        tick();
        idle_io();
        chk("wrerr_pulse", wr_err, 1);
        tick();
        chk("wrerr_once", wr_err, 0);
        chk("oor_cnt", active_cnt, 5);
        drive_rd(PN, 0);
        tick();
        idle_io();
        wait_q("q_oor");

        // Swap with reads in flight, drain-time read ignored, repeat req ignored
        drive_wr(0, rec(7));
        tick();
        idle_io();
        drive_rd(1, 1);
        tick();
        drive_rd(2, 1);
        swap_req = 1'b1;
        tick();
        drive_rd(3, 0);
        drive_wr(7, rec(207));
        tick();
        idle_io();
        chk("swap2_busy", busy, 1);
        chk("swap2_nodone", swap_done, 0);
        repeat (L - 1) tick();
        drive_wr(6, rec(206));
        tick();
        idle_io();
        mbank = 1'b0;
        chk("swap2_done", swap_done, 1);
        chk("swap2_clr", busy, 0);
        chk("swap2_cnt", active_cnt, 7);
        swap_req = 1'b0;
        tick();
        chk("swap2_once", swap_done, 0);
        chk("swap2_nobusy", busy, 0);
        wait_q("q_swap2");

        drive_rd(6, 1);
        tick();
        drive_rd(7, 1);
        tick();
        drive_rd(2, 1);
        tick();
        idle_io();
        wait_q("q_newbank");

        // Reset the cycle after swap_req
        swap_req = 1'b1;
        tick();
        rst = 1'b1;
        swap_req = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_cnt", active_cnt, 0);
        chk("arst_done", swap_done, 0);
        tick();
        tick();
        chk("arst_done2", swap_done, 0);
        rst = 1'b0;
        mbank = 1'b0;
        tick();
        chk("post_busy", busy, 0);
        chk("post_done", swap_done, 0);
        chk("post_cnt", active_cnt, 0);
        drive_rd(1, 1);
        tick();
        idle_io();
        wait_q("q_post");

        drive_wr(0, rec(9));
        tick();
        idle_io();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        tick();
        tick();
        mbank = 1'b1;
        chk("swap3_done", swap_done, 1);
        chk("swap3_cnt", active_cnt, 9);
        drive_rd(4, 1);
        tick();
        idle_io();
        wait_q("q_final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
